// File: rtl/sprite_scanline_renderer.sv
// Sprite scanline renderer: fetches one bitmap ROM row per video line during
// horizontal blank, then shifts it out as a 1-bit pixel stream from hstart.
module sprite_scanline_renderer #(
   parameter int BMP_W  = 8,
   parameter int BMP_H  = 16,
   parameter bit MIRROR = 1'b1,
   localparam int AW    = $clog2(BMP_H)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vstart,
   input  logic             load,
   input  logic             hstart,
   output logic [AW-1:0]    rom_addr,
   input  logic [BMP_W-1:0] rom_bits,
   output logic             gfx,
   output logic             in_progress
);

   localparam int XW   = $clog2(2 * BMP_W);
   localparam int BW   = (BMP_W > 1) ? $clog2(BMP_W) : 1;
   localparam int NPIX = MIRROR ? 2 * BMP_W : BMP_W;

   localparam logic [XW-1:0] X_LAST    = XW'(NPIX - 1);
   localparam logic [XW-1:0] X_HALF    = XW'(BMP_W);
   localparam logic [XW-1:0] X_MIR_TOP = XW'(2 * BMP_W - 1);
   localparam logic [AW:0]   Y_DONE    = (AW + 1)'(BMP_H);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WAIT_LOAD   = 3'd1,
      LOAD_SETUP  = 3'd2,
      LOAD_FETCH  = 3'd3,
      WAIT_HSTART = 3'd4,
      DRAW        = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [AW:0]        ycount_q, ycount_d;
   logic [XW-1:0]      xcount_q, xcount_d;
   logic [BMP_W-1:0]   rowbuf_q, rowbuf_d;
   logic [AW-1:0]      rom_addr_q, rom_addr_d;
   logic [XW-1:0]      mir_pos_s;
   logic [BW-1:0]      pix_idx_s;
   logic               gfx_s;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ycount_q   <= '0;
         xcount_q   <= '0;
         rowbuf_q   <= '0;
         rom_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         ycount_q   <= ycount_d;
         xcount_q   <= xcount_d;
         rowbuf_q   <= rowbuf_d;
         rom_addr_q <= rom_addr_d;
      end
   end

   // Next-state logic; events not expected in the current state fall through unchanged.
   always_comb begin
      state_d    = state_q;
      ycount_d   = ycount_q;
      xcount_d   = xcount_q;
      rowbuf_d   = rowbuf_q;
      rom_addr_d = rom_addr_q;
      case (state_q)
         IDLE: begin
            if (vstart) begin
               state_d  = WAIT_LOAD;
               ycount_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_LOAD: begin
            if (load) begin
               state_d    = LOAD_SETUP;
               rom_addr_d = ycount_q[AW-1:0];
            end else begin
               state_d = WAIT_LOAD;
            end
         end
         LOAD_SETUP: state_d = LOAD_FETCH;
         LOAD_FETCH: begin
            rowbuf_d = rom_bits;
            ycount_d = ycount_q + (AW + 1)'(1);
            state_d  = WAIT_HSTART;
         end
         WAIT_HSTART: begin
            if (hstart) begin
               state_d  = DRAW;
               xcount_d = '0;
            end else begin
               state_d = WAIT_HSTART;
            end
         end
         DRAW: begin
            xcount_d = xcount_q + XW'(1);
            if (xcount_q == X_LAST) begin
               state_d = (ycount_q == Y_DONE) ? IDLE : WAIT_LOAD;
            end else begin
               state_d = DRAW;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pixel select: second half walks the row backwards for the mirrored image.
   always_comb begin
      mir_pos_s = X_MIR_TOP - xcount_q;
      pix_idx_s = '0;
      gfx_s     = 1'b0;
      if (state_q == DRAW) begin
         if (xcount_q < X_HALF) begin
            pix_idx_s = xcount_q[BW-1:0];
         end else begin
            pix_idx_s = mir_pos_s[BW-1:0];
         end
         gfx_s = rowbuf_q[pix_idx_s];
      end else begin
         gfx_s = 1'b0;
      end
   end

   assign gfx         = gfx_s;
   assign in_progress = (state_q != IDLE);
   assign rom_addr    = rom_addr_q;

endmodule

// File: tb/tb_sprite_scanline_renderer.sv
// Self-checking bench: a mirrored and a non-mirrored renderer share stimulus
// and are compared against an event-timestamp reference model.
module tb_sprite_scanline_renderer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       vstart = 1'b0, load = 1'b0, hstart = 1'b0;
   logic [3:0] rom_addr_m, rom_addr_n;
   logic [7:0] rom_bits_m, rom_bits_n;
   logic       gfx_m, gfx_n, inprog_m, inprog_n;
   logic [7:0] rom_m [16];
   logic [7:0] rom_n [16];

   assign rom_bits_m = rom_m[rom_addr_m];
   assign rom_bits_n = rom_n[rom_addr_n];

   sprite_scanline_renderer #(.BMP_W(8), .BMP_H(16), .MIRROR(1'b1)) u_dut_m (
      .clk(clk), .reset(reset), .vstart(vstart), .load(load), .hstart(hstart),
      .rom_addr(rom_addr_m), .rom_bits(rom_bits_m), .gfx(gfx_m), .in_progress(inprog_m));

   sprite_scanline_renderer #(.BMP_W(8), .BMP_H(16), .MIRROR(1'b0)) u_dut_n (
      .clk(clk), .reset(reset), .vstart(vstart), .load(load), .hstart(hstart),
      .rom_addr(rom_addr_n), .rom_bits(rom_bits_n), .gfx(gfx_n), .in_progress(inprog_n));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int t        = 0;

   // Reference model, index 0 = non-mirrored, 1 = mirrored; tracks cycle
   // stamps of the accepted load and hstart instead of a state machine.
   bit         mbusy [2];
   int         mrow  [2];
   int         mlt   [2];
   int         mht   [2];
   logic [3:0] maddr [2];
   logic [7:0] mbits [2];
   int         npix  [2] = '{8, 16};

   typedef struct {
      logic       vs, ld, hs;
      logic       e_gm, e_gn, e_busy;
      logic [3:0] e_addr;
   } vec_t;
   vec_t tbl [38];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
      end
   endtask

   function automatic logic [7:0] rom_read(input int k, input logic [3:0] a);
      return (k == 1) ? rom_m[a] : rom_n[a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mbusy[k] = 1'b0; mrow[k] = 0; mlt[k] = -1; mht[k] = -1;
         maddr[k] = 4'd0; mbits[k] = 8'd0;
      end
   endtask

   task automatic model_step(input int k, input logic vs, input logic ld, input logic hs);
      if (!mbusy[k]) begin
         if (vs) begin
            mbusy[k] = 1'b1; mrow[k] = 0; mlt[k] = -1; mht[k] = -1;
         end
      end else if (mht[k] >= 0) begin
         if (t == mht[k] + npix[k]) begin
            mht[k] = -1; mlt[k] = -1;
            if (mrow[k] == 16) mbusy[k] = 1'b0;
         end
      end else if (mlt[k] < 0) begin
         if (ld) begin
            mlt[k] = t; maddr[k] = mrow[k][3:0];
         end
      end else if (t == mlt[k] + 2) begin
         mbits[k] = rom_read(k, maddr[k]);
         mrow[k]  = mrow[k] + 1;
      end else if (t >= mlt[k] + 3) begin
         if (hs) mht[k] = t;
      end
   endtask

   function automatic int exp_gfx(input int k);
      int i;
      if (mht[k] < 0) return 0;
      i = t - mht[k];
      if (i >= npix[k]) return 0;
      return (i < 8) ? int'(mbits[k][i]) : int'(mbits[k][15 - i]);
   endfunction

   task automatic check_model();
      check("gfx_m", int'(gfx_m), exp_gfx(1));
      check("busy_m", int'(inprog_m), int'(mbusy[1]));
      check("addr_m", int'(rom_addr_m), int'(maddr[1]));
      check("gfx_n", int'(gfx_n), exp_gfx(0));
      check("busy_n", int'(inprog_n), int'(mbusy[0]));
      check("addr_n", int'(rom_addr_n), int'(maddr[0]));
   endtask

   task automatic tick(input logic vs, input logic ld, input logic hs);
      vstart = vs; load = ld; hstart = hs;
      @(posedge clk);
      t++;
      for (int k = 0; k < 2; k++) model_step(k, vs, ld, hs);
      #1;
      vstart = 1'b0; load = 1'b0; hstart = 1'b0;
      check_model();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop before any edge.
   task automatic do_reset();
      #2;
      reset = 1'b0;
      #1;
      check("rst_gfx_m", int'(gfx_m), 0);
      check("rst_gfx_n", int'(gfx_n), 0);
      check("rst_busy_m", int'(inprog_m), 0);
      check("rst_busy_n", int'(inprog_n), 0);
      model_reset();
      @(posedge clk);
      t++;
      #1;
      check_model();
      reset = 1'b1;
   endtask

   initial begin
      int ones_m, ones_n, fall_m, fall_n;
      logic [15:0] pm;
      pm = 16'b0011001111001100;
      model_reset();
      for (int a = 0; a < 16; a++) begin
         rom_m[a] = 8'h00; rom_n[a] = 8'h00;
      end
      rom_m[0] = 8'b11001100;
      rom_n[0] = 8'b00000001;

      for (int c = 0; c < 38; c++) tbl[c] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
      tbl[0].vs  = 1'b1;
      tbl[10].ld = 1'b1;
      tbl[20].hs = 1'b1;
      for (int i = 0; i < 16; i++) tbl[20 + i].e_gm = pm[15 - i];
      tbl[20].e_gn = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("init_gfx_m", int'(gfx_m), 0);
      check("init_busy_m", int'(inprog_m), 0);
      check("init_addr_m", int'(rom_addr_m), 0);
      check("init_gfx_n", int'(gfx_n), 0);
      check("init_busy_n", int'(inprog_n), 0);
      check("init_addr_n", int'(rom_addr_n), 0);
      reset = 1'b1;

      // Basic row: mirrored 0xCC and non-mirrored 0x01 from the vector table.
      for (int c = 0; c < 38; c++) begin
         tick(tbl[c].vs, tbl[c].ld, tbl[c].hs);
         check("tbl_gfx_m", int'(gfx_m), int'(tbl[c].e_gm));
         check("tbl_gfx_n", int'(gfx_n), int'(tbl[c].e_gn));
         check("tbl_busy_m", int'(inprog_m), int'(tbl[c].e_busy));
         check("tbl_addr_m", int'(rom_addr_m), int'(tbl[c].e_addr));
      end

      // Spacing boundary: hstart at L+2 is lost.
      rom_m[1] = 8'hFF; rom_n[1] = 8'hFF;
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      ones_m = 0; ones_n = 0;
      for (int j = 0; j < 20; j++) begin
         tick(1'b0, 1'b0, 1'b0);
         ones_m += int'(gfx_m); ones_n += int'(gfx_n);
      end
      check("spacing_l2_m", ones_m, 0);
      check("spacing_l2_n", ones_n, 0);

      // Spacing boundary: hstart at L+3 is drawn.
      rom_m[0] = 8'hFF; rom_n[0] = 8'hFF;
      do_reset();
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      ones_m = 0; ones_n = 0;
      tick(1'b0, 1'b0, 1'b1);
      ones_m += int'(gfx_m); ones_n += int'(gfx_n);
      for (int j = 0; j < 19; j++) begin
         tick(1'b0, 1'b0, 1'b0);
         ones_m += int'(gfx_m); ones_n += int'(gfx_n);
      end
      check("spacing_l3_m", ones_m, 16);
      check("spacing_l3_n", ones_n, 8);

      // Reset in the middle of an opaque run.
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      check("pre_reset_gfx_m", int'(gfx_m), 1);
      do_reset();
      check("post_reset_addr_m", int'(rom_addr_m), 0);

      // Spurious vstart/load/hstart while busy.
      for (int a = 0; a < 16; a++) begin
         rom_m[a] = 8'($urandom); rom_n[a] = 8'($urandom);
      end
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b0);
      repeat (15) tick(1'b0, 1'b0, 1'b0);
      check("spurious_addr_m", int'(rom_addr_m), 0);
      check("spurious_addr_n", int'(rom_addr_n), 0);

      // Full 16-line sprite, hstart 40 cycles after each load.
      do_reset();
      tick(1'b1, 1'b0, 1'b0);
      fall_m = -1; fall_n = -1;
      for (int r = 0; r < 16; r++) begin
         tick(1'b0, 1'b1, 1'b0);
         check("full_addr_m", int'(rom_addr_m), r);
         repeat (39) tick(1'b0, 1'b0, 1'b0);
         tick(1'b0, 1'b0, 1'b1);
         if (r == 15) begin
            for (int j = 1; j <= 40; j++) begin
               tick(1'b0, 1'b0, 1'b0);
               if (!inprog_m && fall_m < 0) fall_m = j;
               if (!inprog_n && fall_n < 0) fall_n = j;
            end
         end else begin
            repeat (20) tick(1'b0, 1'b0, 1'b0);
         end
      end
      check("full_fall_m", fall_m, 16);
      check("full_fall_n", fall_n, 8);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      check("after_sprite_gfx_m", int'(gfx_m), 0);

      // Randomized traffic against the model.
      do_reset();
      for (int j = 0; j < 3000; j++) begin
         tick(logic'($urandom_range(0, 199) == 0),
              logic'($urandom_range(0, 19) == 0),
              logic'($urandom_range(0, 9) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
